// File: rtl/dcache_warmup_pkg.sv
// Shared types and derived widths for the dcache warmup injector.
// The optional readback checker is enabled by defining DCACHE_WARMUP_READBACK_EN.
package dcache_warmup_pkg;

    localparam int unsigned SETS         = 64;
    localparam int unsigned WAYS         = 4;
    localparam int unsigned TAG_BITS     = 22;
    localparam int unsigned ROWS_PER_SET = 8;
    localparam int unsigned ROW_BITS     = WAYS * 64;
    localparam int unsigned TAG_ADDR_W   = $clog2(SETS);
    localparam int unsigned DATA_ADDR_W  = $clog2(SETS * ROWS_PER_SET);
    localparam int unsigned ROW_W        = $clog2(ROWS_PER_SET);
    localparam int unsigned TAG_ROW_BITS = WAYS * TAG_BITS;
    localparam int unsigned DATA_MASK_W  = ROW_BITS / 8;
    localparam int unsigned TAG_REQ_W    = TAG_ADDR_W + 2 + TAG_ROW_BITS + WAYS;
    localparam int unsigned DATA_REQ_W   = DATA_ADDR_W + 2 + ROW_BITS + DATA_MASK_W;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        DATA,
        CHECK,
        DONE
    } state_t;

    // RW0 request layout for tag_array_ext: {addr, en, wmode, wdata, wmask}
    typedef struct packed {
        logic [TAG_ADDR_W-1:0]   addr;
        logic                    en;
        logic                    wmode;
        logic [TAG_ROW_BITS-1:0] wdata;
        logic [WAYS-1:0]         wmask;
    } tag_req_t;

    // RW0 request layout for data_arrays_0_ext: {addr, en, wmode, wdata, wmask}
    typedef struct packed {
        logic [DATA_ADDR_W-1:0] addr;
        logic                   en;
        logic                   wmode;
        logic [ROW_BITS-1:0]    wdata;
        logic [DATA_MASK_W-1:0] wmask;
    } data_req_t;

    // Data-array row address for set s, row r (s*ROWS_PER_SET + r)
    function automatic logic [DATA_ADDR_W-1:0] data_addr(
        input logic [TAG_ADDR_W-1:0] s,
        input logic [ROW_W-1:0]      r
    );
        return {s, r};
    endfunction

endpackage

// File: rtl/dcache_sram_port_mux.sv
// Selects between the warmup injector and the dcache request path for one SRAM RW0 port.
// Read data always returns straight to the dcache.
module dcache_sram_port_mux #(
    parameter int unsigned REQ_W   = 100,
    parameter int unsigned RDATA_W = 88
) (
    input  logic               inj_sel,
    input  logic [REQ_W-1:0]   inj_req,
    input  logic [REQ_W-1:0]   c_req,
    output logic [REQ_W-1:0]   sram_req,
    input  logic [RDATA_W-1:0] sram_rdata,
    output logic [RDATA_W-1:0] c_rdata
);

    // Injector owns the port while selected; dcache requests are dropped, not queued
    always_comb begin
        sram_req = inj_sel ? inj_req : c_req;
        c_rdata  = sram_rdata;
    end

endmodule

// File: rtl/dcache_warmup_injector.sv
// Writes a preload stream into the dcache tag/data SRAMs through their RW0 ports,
// then hands the ports back to the dcache. Optional per-write readback checking is
// enabled by defining DCACHE_WARMUP_READBACK_EN (adds the mismatch_cnt port).
module dcache_warmup_injector
    import dcache_warmup_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [ROW_BITS-1:0]     ld_data,
    input  logic [TAG_REQ_W-1:0]    c_tag_req,
    output logic [TAG_ROW_BITS-1:0] c_tag_rdata,
    input  logic [DATA_REQ_W-1:0]   c_data_req,
    output logic [ROW_BITS-1:0]     c_data_rdata,
    output logic                    c_grant,
    output logic [TAG_REQ_W-1:0]    tag_req,
    input  logic [TAG_ROW_BITS-1:0] tag_rdata,
    output logic [DATA_REQ_W-1:0]   data_req,
    input  logic [ROW_BITS-1:0]     data_rdata
`ifdef DCACHE_WARMUP_READBACK_EN
    ,
    output logic [15:0]             mismatch_cnt
`endif
);

    state_t                 state;
    state_t                 state_nxt;
    state_t                 adv_state;
    logic                   accept;
    logic                   last_row;
    logic                   last_set;
    logic [TAG_ADDR_W-1:0]  set_cnt;
    logic [ROW_W-1:0]       row_cnt;
    tag_req_t               inj_tag;
    data_req_t              inj_data;

`ifdef DCACHE_WARMUP_READBACK_EN
    state_t                 ret_state;
    logic                   chk_tag;
    logic                   cmp_pend;
    logic                   rd_mismatch;
    logic [TAG_ADDR_W-1:0]  chk_taddr;
    logic [DATA_ADDR_W-1:0] chk_daddr;
    logic [ROW_BITS-1:0]    chk_word;
`endif

    assign last_row = (row_cnt == ROW_W'(ROWS_PER_SET - 1));
    assign last_set = (set_cnt == TAG_ADDR_W'(SETS - 1));
    assign c_grant  = ~busy;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake and injector write/read requests
    always_comb begin
        state_nxt = state;
        adv_state = state;
        accept    = 1'b0;
        ld_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        inj_tag   = '0;
        inj_data  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = TAG;
                end
            end
            TAG: begin
                ld_ready  = 1'b1;
                busy      = 1'b1;
                accept    = ld_valid;
                adv_state = DATA;
                if (accept) begin
                    inj_tag.addr  = set_cnt;
                    inj_tag.en    = 1'b1;
                    inj_tag.wmode = 1'b1;
                    inj_tag.wdata = ld_data[TAG_ROW_BITS-1:0];
                    inj_tag.wmask = '1;
                end
            end
            DATA: begin
                ld_ready  = 1'b1;
                busy      = 1'b1;
                accept    = ld_valid;
                adv_state = last_row ? (last_set ? DONE : TAG) : DATA;
                if (accept) begin
                    inj_data.addr  = data_addr(set_cnt, row_cnt);
                    inj_data.en    = 1'b1;
                    inj_data.wmode = 1'b1;
                    inj_data.wdata = ld_data;
                    inj_data.wmask = '1;
                end
            end
`ifdef DCACHE_WARMUP_READBACK_EN
            CHECK: begin
                busy      = 1'b1;
                state_nxt = ret_state;
                if (chk_tag) begin
                    inj_tag.addr  = chk_taddr;
                    inj_tag.en    = 1'b1;
                end else begin
                    inj_data.addr = chk_daddr;
                    inj_data.en   = 1'b1;
                end
            end
`endif
            DONE: begin
                done = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (accept) begin
`ifdef DCACHE_WARMUP_READBACK_EN
            state_nxt = CHECK;
`else
            state_nxt = adv_state;
`endif
        end
    end

    // Set/row position in the preload stream; set wraps only on the way into DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            set_cnt <= '0;
            row_cnt <= '0;
        end else if (accept && (state == DATA)) begin
            row_cnt <= row_cnt + ROW_W'(1);
            if (last_row) begin
                set_cnt <= last_set ? '0 : set_cnt + TAG_ADDR_W'(1);
            end
        end
    end

`ifdef DCACHE_WARMUP_READBACK_EN
    assign rd_mismatch = chk_tag ? (tag_rdata != chk_word[TAG_ROW_BITS-1:0])
                                 : (data_rdata != chk_word);

    // Remember each write for its CHECK read; compare one cycle after the read
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_state    <= IDLE;
            chk_tag      <= 1'b0;
            chk_taddr    <= '0;
            chk_daddr    <= '0;
            chk_word     <= '0;
            cmp_pend     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            cmp_pend <= (state == CHECK);
            if (accept) begin
                chk_tag   <= (state == TAG);
                chk_taddr <= set_cnt;
                chk_daddr <= data_addr(set_cnt, row_cnt);
                chk_word  <= (state == TAG) ? ROW_BITS'(ld_data[TAG_ROW_BITS-1:0]) : ld_data;
                ret_state <= adv_state;
            end
            if (cmp_pend && rd_mismatch && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + 16'd1;
            end
        end
    end
`endif

    dcache_sram_port_mux #(
        .REQ_W   (TAG_REQ_W),
        .RDATA_W (TAG_ROW_BITS)
    ) u_tag_mux (
        .inj_sel    (busy),
        .inj_req    (inj_tag),
        .c_req      (c_tag_req),
        .sram_req   (tag_req),
        .sram_rdata (tag_rdata),
        .c_rdata    (c_tag_rdata)
    );

    dcache_sram_port_mux #(
        .REQ_W   (DATA_REQ_W),
        .RDATA_W (ROW_BITS)
    ) u_data_mux (
        .inj_sel    (busy),
        .inj_req    (inj_data),
        .c_req      (c_data_req),
        .sram_req   (data_req),
        .sram_rdata (data_rdata),
        .c_rdata    (c_data_rdata)
    );

endmodule
